// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// PC step size and small address helpers.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        ISSUE = 2'd3
    } fetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Fetch addresses are always word aligned; the two low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter with increment and redirect load, plus the register
// that parks a redirect target while an abandoned request drains.
module fetch_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic        pend_load,
    input  logic [31:0] pend_val,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pend_pc
);
    import fetch_pkg::*;

    // Wraps modulo 2^32 naturally through the 32-bit adder.
    assign pc_plus4 = pc + PC_STEP;

    // PC: a redirect load takes priority over sequential advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= word_align(load_pc);
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

    // Pending redirect target, latest redirect overwrites an earlier one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_pc <= 32'h0000_0000;
        end else if (pend_load) begin
            pend_pc <= word_align(pend_val);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: runs the req/ack handshake to instruction
// memory, presents one instruction at a time and handles redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] out_add,
    output logic [31:0] out_ins,
    output logic [31:0] out_jump,
    output logic        out_valid
);
    import fetch_pkg::*;

    fetch_state_e state, state_n;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pend_pc;

    logic        pc_inc;
    logic        pc_load;
    logic [31:0] pc_load_val;
    logic        pend_load;
    logic        cap;
    logic        vld_clr;

    logic [31:0] add_p1;
    logic [31:0] ins_p1;
    logic [31:0] jump_p1;
    logic        vld_p1;

    // J-type target formed from the upper PC+4 nibble and the 26-bit index.
    function automatic logic [31:0] jump_target(input logic [31:0] next_pc,
                                                input logic [31:0] ins);
        return {next_pc[31:28], ins[25:0], 2'b00};
    endfunction

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .inc       (pc_inc),
        .load      (pc_load),
        .load_pc   (pc_load_val),
        .pend_load (pend_load),
        .pend_val  (redirect_pc),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .pend_pc   (pend_pc)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and PC/output control; a started request is never withdrawn.
    always_comb begin
        state_n     = state;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = redirect_pc;
        pend_load   = 1'b0;
        cap         = 1'b0;
        vld_clr     = 1'b0;
        case (state)
            IDLE: begin
                state_n = FETCH;
            end
            FETCH: begin
                if (mem_ack) begin
                    if (redirect) begin
                        pc_load = 1'b1;
                    end else begin
                        cap     = 1'b1;
                        pc_inc  = 1'b1;
                        state_n = ISSUE;
                    end
                end else if (redirect) begin
                    pend_load = 1'b1;
                    state_n   = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    pc_load     = 1'b1;
                    pc_load_val = redirect ? redirect_pc : pend_pc;
                    state_n     = FETCH;
                end else if (redirect) begin
                    pend_load = 1'b1;
                end
            end
            ISSUE: begin
                if (redirect) begin
                    vld_clr = 1'b1;
                    pc_load = 1'b1;
                    state_n = FETCH;
                end else if (!stall) begin
                    vld_clr = 1'b1;
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign mem_req  = (state == FETCH) || (state == DRAIN);
    assign mem_addr = pc;

    // Output register: captures an accepted fetch, holds it until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_p1  <= 32'h0000_0000;
            ins_p1  <= 32'h0000_0000;
            jump_p1 <= 32'h0000_0000;
            vld_p1  <= 1'b0;
        end else if (cap) begin
            add_p1  <= pc_plus4;
            ins_p1  <= mem_rdata;
            jump_p1 <= jump_target(pc_plus4, mem_rdata);
            vld_p1  <= 1'b1;
        end else if (vld_clr) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_add   = add_p1;
    assign out_ins   = ins_p1;
    assign out_jump  = jump_p1;
    assign out_valid = vld_p1;

endmodule
